// File: rtl/fan_off_timer.sv
// rtl/fan_off_timer.sv - auto-off countdown timer, BCD mm:ss output for the FND controller
module fan_off_timer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter logic [7:0]  PRESET_A = 8'h01,
  parameter logic [7:0]  PRESET_B = 8'h03,
  parameter logic [7:0]  PRESET_C = 8'h05
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_pulse,
  input  logic        clear,
  output logic [15:0] value,
  output logic        timer_active,
  output logic        timeout,
  output logic [1:0]  preset_sel
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [15:0]   value_q;
  logic [1:0]    sel_q;
  logic [PW-1:0] presc_q;
  logic          timeout_q;

  logic [1:0]    sel_d;
  logic          tick;

  // Minutes for a given selector; selector 0 is OFF and never loaded.
  function automatic logic [7:0] preset_min(input logic [1:0] sel);
    case (sel)
      2'd1:    preset_min = PRESET_A;
      2'd2:    preset_min = PRESET_B;
      2'd3:    preset_min = PRESET_C;
      default: preset_min = 8'h00;
    endcase
  endfunction

  // One-second decrement of a BCD mm:ss value; seconds wrap 00->59, minutes units 0->9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] d3, d2, d1, d0;
    logic       b;
    {d3, d2, d1, d0} = v;
    b = 1'b0;
    if (d0 == 4'd0) begin
      d0 = 4'd9;
      b  = 1'b1;
    end else begin
      d0 = d0 - 4'd1;
    end
    if (b) begin
      if (d1 == 4'd0) begin
        d1 = 4'd5;
      end else begin
        d1 = d1 - 4'd1;
        b  = 1'b0;
      end
    end
    if (b) begin
      if (d2 == 4'd0) begin
        d2 = 4'd9;
      end else begin
        d2 = d2 - 4'd1;
        b  = 1'b0;
      end
    end
    if (b) begin
      d3 = d3 - 4'd1;
    end
    bcd_dec = {d3, d2, d1, d0};
  endfunction

  assign sel_d = sel_q + 2'd1;
  assign tick  = (state_q == RUN) && (presc_q == TICK_LAST);

  // Timer FSM: clear beats set_pulse beats the one-second tick; all outputs registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      value_q   <= 16'h0000;
      sel_q     <= 2'd0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        value_q <= 16'h0000;
        sel_q   <= 2'd0;
        presc_q <= '0;
      end else if (set_pulse) begin
        sel_q   <= sel_d;
        presc_q <= '0;
        if (sel_d == 2'd0) begin
          state_q <= IDLE;
          value_q <= 16'h0000;
        end else begin
          state_q <= RUN;
          value_q <= {preset_min(sel_d), 8'h00};
        end
      end else if (state_q == RUN) begin
        if (tick) begin
          presc_q <= '0;
          if (value_q == 16'h0001) begin
            state_q   <= IDLE;
            value_q   <= 16'h0000;
            sel_q     <= 2'd0;
            timeout_q <= 1'b1;
          end else begin
            value_q <= bcd_dec(value_q);
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end else begin
        presc_q <= '0;
      end
    end
  end

  assign value        = value_q;
  assign timer_active = (state_q == RUN);
  assign timeout      = timeout_q;
  assign preset_sel   = sel_q;

endmodule

// File: tb/tb_fan_off_timer.sv
// tb/tb_fan_off_timer.sv - randomized self-checking bench for fan_off_timer
module tb_fan_off_timer;

  localparam int TICK_DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_pulse;
  logic        clear;
  logic [15:0] value;
  logic        timer_active;
  logic        timeout;
  logic [1:0]  preset_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining whole seconds and cycles since the last load/tick.
  int m_rem;
  int m_sel;
  bit m_active;
  int m_elapsed;
  bit m_timeout;

  fan_off_timer #(
    .TICK_DIV (TICK_DIV),
    .PRESET_A (8'h01),
    .PRESET_B (8'h03),
    .PRESET_C (8'h05)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .set_pulse    (set_pulse),
    .clear        (clear),
    .value        (value),
    .timer_active (timer_active),
    .timeout      (timeout),
    .preset_sel   (preset_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int preset_minutes(input int sel);
    case (sel)
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] model_value();
    int mm, ss;
    mm = m_rem / 60;
    ss = m_rem % 60;
    return 16'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
  endfunction

  task automatic model_reset();
    m_rem = 0; m_sel = 0; m_active = 0; m_elapsed = 0; m_timeout = 0;
  endtask

  task automatic model_edge(input bit s, input bit c);
    m_timeout = 0;
    if (c) begin
      m_rem = 0; m_sel = 0; m_active = 0; m_elapsed = 0;
    end else if (s) begin
      m_sel = (m_sel + 1) % 4;
      m_elapsed = 0;
      m_rem = preset_minutes(m_sel) * 60;
      m_active = (m_sel != 0);
    end else if (m_active) begin
      m_elapsed++;
      if (m_elapsed == TICK_DIV) begin
        m_elapsed = 0;
        m_rem--;
        if (m_rem == 0) begin
          m_active = 0; m_sel = 0; m_timeout = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("value", value, model_value());
    chk("timer_active", 16'(timer_active), 16'(m_active));
    chk("timeout", 16'(timeout), 16'(m_timeout));
    chk("preset_sel", 16'(preset_sel), 16'(m_sel));
  endtask

  task automatic step(input bit s, input bit c);
    set_pulse = s;
    clear     = c;
    @(posedge clk);
    model_edge(s, c);
    #1;
    set_pulse = 1'b0;
    clear     = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    set_pulse = 1'b0;
    clear     = 1'b0;
    do_reset();

    // Idle after reset: nothing moves.
    idle(100);

    // Preset A full countdown to natural expiry.
    step(1'b1, 1'b0);
    chk("load_a", value, 16'h0100);
    idle(TICK_DIV);
    chk("first_tick", value, 16'h0059);
    idle(59 * TICK_DIV);
    chk("expiry_pulse", 16'(timeout), 16'h0001);
    idle(1);
    chk("pulse_one_cycle", 16'(timeout), 16'h0000);

    // Cycle through every preset back to OFF.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      idle(2);
    end
    chk("cycle_end_active", 16'(timer_active), 16'h0000);

    // 03:00 for 61 ticks, crossing minute borrows, then clear at 02:47 with set ignored.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("load_b", value, 16'h0300);
    idle(13 * TICK_DIV);
    chk("at_0247", value, 16'h0247);
    step(1'b1, 1'b1);
    chk("clear_value", value, 16'h0000);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(61 * TICK_DIV);
    chk("at_0159", value, 16'h0159);

    // set_pulse on the expiry tick of preset A loads preset B, no timeout.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(60 * TICK_DIV - 1);
    chk("pre_expiry", value, 16'h0001);
    step(1'b1, 1'b0);
    chk("expiry_set_value", value, 16'h0300);
    chk("expiry_set_sel", 16'(preset_sel), 16'h0002);
    chk("expiry_set_timeout", 16'(timeout), 16'h0000);

    // Asynchronous reset mid-run clears outputs before the next edge.
    idle(25);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_value", value, 16'h0000);
    chk("async_active", 16'(timer_active), 16'h0000);
    chk("async_sel", 16'(preset_sel), 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(30);

    // Randomized set/clear traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      step(r < 15, r >= 995);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
